// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU tile scheduler.
// The array and global buffer use the same defaults.
package tpu_pkg;

  localparam int ARR_DEF   = 4;
  localparam int DIM_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/tpu_tile_scheduler_if.sv
// Tile command channel between the scheduler
// and the systolic array.
interface tpu_tile_scheduler_if #(
  parameter int ARR   = 4,
  parameter int DIM_W = 4
) ();

  localparam int SZ_W = $clog2(ARR) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIM_W-1:0] cmd_row_base;
  logic [DIM_W-1:0] cmd_col_base;
  logic [SZ_W-1:0]  cmd_rows;
  logic [SZ_W-1:0]  cmd_cols;
  logic [DIM_W-1:0] cmd_k;
  logic             tile_done;

  modport master (
    output cmd_valid,
    output cmd_row_base,
    output cmd_col_base,
    output cmd_rows,
    output cmd_cols,
    output cmd_k,
    input  cmd_ready,
    input  tile_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_row_base,
    input  cmd_col_base,
    input  cmd_rows,
    input  cmd_cols,
    input  cmd_k,
    output cmd_ready,
    output tile_done
  );

endinterface

// File: rtl/tpu_tile_scheduler_tile_counter.sv
// Row-major tile walker: registered bases, clamped
// tile sizes and a last-tile flag.
module tile_counter
  import tpu_pkg::*;
#(
  parameter int ARR   = ARR_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic                    step,
  input  logic [DIM_W-1:0]        dim_m,
  input  logic [DIM_W-1:0]        dim_n,
  output logic [DIM_W-1:0]        row_base,
  output logic [DIM_W-1:0]        col_base,
  output logic [$clog2(ARR):0]    rows,
  output logic [$clog2(ARR):0]    cols,
  output logic                    last
);

  localparam int SZ_W = $clog2(ARR) + 1;
  localparam int EW   = DIM_W + 1;
  localparam logic [EW-1:0] ARR_E = EW'(ARR);

  logic [EW-1:0] rb_q;
  logic [EW-1:0] cb_q;
  logic [EW-1:0] rb_d;
  logic [EW-1:0] cb_d;
  logic [EW-1:0] m_e;
  logic [EW-1:0] n_e;
  logic          col_last;

  function automatic logic [SZ_W-1:0] clamp(
    input logic [EW-1:0] dim,
    input logic [EW-1:0] base
  );
    logic [EW-1:0] rem;
    rem = dim - base;
    if (rem >= ARR_E) return SZ_W'(ARR);
    return SZ_W'(rem);
  endfunction

  assign m_e      = {1'b0, dim_m};
  assign n_e      = {1'b0, dim_n};
  assign col_last = (cb_q + ARR_E) >= n_e;
  assign last     = col_last && ((rb_q + ARR_E) >= m_e);
  assign row_base = rb_q[DIM_W-1:0];
  assign col_base = cb_q[DIM_W-1:0];

  // next tile position: column inner, row outer
  always_comb begin
    rb_d = rb_q;
    cb_d = cb_q;
    if (init) begin
      rb_d = '0;
      cb_d = '0;
    end else if (step) begin
      if (col_last) begin
        cb_d = '0;
        rb_d = rb_q + ARR_E;
      end else begin
        cb_d = cb_q + ARR_E;
      end
    end
  end

  // register position and the clamped tile size
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_q <= '0;
      cb_q <= '0;
      rows <= '0;
      cols <= '0;
    end else if (init || step) begin
      rb_q <= rb_d;
      cb_q <= cb_d;
      rows <= clamp(m_e, rb_d);
      cols <= clamp(n_e, cb_d);
    end
  end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Issues ARR x ARR output tiles of one matmul
// to the systolic array, row-major.
module tpu_tile_scheduler
  import tpu_pkg::*;
#(
  parameter int ARR   = ARR_DEF,
  parameter int DIM_W = DIM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     m,
  input  logic [DIM_W-1:0]     n,
  input  logic [DIM_W-1:0]     k,
  tpu_tile_scheduler_if.master cmd,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     cycle_cnt
);

  state_t           state;
  logic [DIM_W-1:0] m_q;
  logic [DIM_W-1:0] n_q;
  logic [DIM_W-1:0] k_q;
  logic [DIM_W-1:0] dm;
  logic [DIM_W-1:0] dn;
  logic             zero_dim;
  logic             cnt_init;
  logic             cnt_step;
  logic             last;

  assign zero_dim = (m == '0) || (n == '0) || (k == '0);
  assign cnt_init = (state == IDLE) && start && !zero_dim;
  assign cnt_step = (state == WAIT) && cmd.tile_done && !last;
  assign dm       = (state == IDLE) ? m : m_q;
  assign dn       = (state == IDLE) ? n : n_q;
  assign cmd.cmd_k = k_q;

  tile_counter #(
    .ARR   (ARR),
    .DIM_W (DIM_W)
  ) u_tiles (
    .clk      (clk),
    .rst      (rst),
    .init     (cnt_init),
    .step     (cnt_step),
    .dim_m    (dm),
    .dim_n    (dn),
    .row_base (cmd.cmd_row_base),
    .col_base (cmd.cmd_col_base),
    .rows     (cmd.cmd_rows),
    .cols     (cmd.cmd_cols),
    .last     (last)
  );

  // control FSM with registered outputs and busy counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      m_q           <= '0;
      n_q           <= '0;
      k_q           <= '0;
      cmd.cmd_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cycle_cnt     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (busy && (cycle_cnt != '1))
        cycle_cnt <= cycle_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            m_q       <= m;
            n_q       <= n;
            k_q       <= k;
            cycle_cnt <= '0;
            busy      <= 1'b1;
            if (zero_dim) begin
              state <= FINISH;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state         <= ISSUE;
              cmd.cmd_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cmd.cmd_ready) begin
            state         <= WAIT;
            cmd.cmd_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (cmd.tile_done) begin
            if (last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state         <= ISSUE;
              cmd.cmd_valid <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Bench for tpu_tile_scheduler: directed ops checked
// against a tile-list protocol model every cycle.
module tb_tpu_tile_scheduler;

  localparam int ARR   = 4;
  localparam int DIM_W = 4;
  localparam int CNT_W = 16;

  typedef struct {
    int rb;
    int cb;
    int rows;
    int cols;
    int kk;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [DIM_W-1:0] m = '0;
  logic [DIM_W-1:0] n = '0;
  logic [DIM_W-1:0] k = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] cycle_cnt;
  logic             arr_done = 1'b0;
  logic             stray = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dones = 0;
  int arr_delay = 4;

  cmd_t tq[$];
  cmd_t q[$];
  bit   op_active = 0;
  bit   exp_valid = 0;
  bit   awaiting = 0;
  bit   finishing = 0;
  bit   exp_done = 0;
  bit   exp_err = 0;
  int   s_cyc = 0;
  int   last_total = 0;

  tpu_tile_scheduler_if #(.ARR(ARR), .DIM_W(DIM_W)) bus ();

  assign bus.tile_done = arr_done | stray;

  tpu_tile_scheduler #(
    .ARR   (ARR),
    .DIM_W (DIM_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .m         (m),
    .n         (n),
    .k         (k),
    .cmd       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // expected tile list straight from the tiling rule
  function automatic void build(int mm, int nn, int kk);
    cmd_t c;
    tq.delete();
    for (int r = 0; r < mm; r += ARR)
      for (int cc = 0; cc < nn; cc += ARR) begin
        c.rb   = r;
        c.cb   = cc;
        c.rows = (mm - r) < ARR ? mm - r : ARR;
        c.cols = (nn - cc) < ARR ? nn - cc : ARR;
        c.kk   = kk;
        tq.push_back(c);
      end
  endfunction

  // array stand-in: tile_done arr_delay cycles after handshake
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (rst && bus.cmd_valid && bus.cmd_ready) begin
        d = arr_delay;
        @(posedge clk);
        repeat (d - 1) @(posedge clk);
        #1;
        if (rst) arr_done = 1'b1;
        @(posedge clk);
        #1 arr_done = 1'b0;
      end
    end
  end

  // per-cycle compare against the model, then advance it
  always @(negedge clk) begin
    bit nd;
    bit ne;
    if (!rst) begin
      chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_cnt", int'(cycle_cnt), 0);
      q.delete();
      op_active  = 0;
      exp_valid  = 0;
      awaiting   = 0;
      finishing  = 0;
      exp_done   = 0;
      exp_err    = 0;
      last_total = 0;
    end else begin
      chk("cmd_valid", int'(bus.cmd_valid), int'(exp_valid));
      if (exp_valid) begin
        if (q.size() == 0) begin
          chk("cmd_extra", 1, 0);
        end else begin
          chk("row_base", int'(bus.cmd_row_base), q[0].rb);
          chk("col_base", int'(bus.cmd_col_base), q[0].cb);
          chk("rows", int'(bus.cmd_rows), q[0].rows);
          chk("cols", int'(bus.cmd_cols), q[0].cols);
          chk("cmd_k", int'(bus.cmd_k), q[0].kk);
        end
      end
      chk("done", int'(done), int'(exp_done));
      if (exp_done) chk("err", int'(err), int'(exp_err));
      chk("busy", int'(busy), int'(op_active));
      chk("cycle_cnt", int'(cycle_cnt),
          op_active ? cyc - s_cyc : last_total);
      if (done) dones++;
      nd = 0;
      ne = 0;
      if (finishing) begin
        op_active  = 0;
        finishing  = 0;
        last_total = cyc - s_cyc + 1;
      end else if (!op_active) begin
        if (start) begin
          op_active = 1;
          s_cyc     = cyc + 1;
          if (m == 0 || n == 0 || k == 0) begin
            nd        = 1;
            ne        = 1;
            finishing = 1;
          end else begin
            build(int'(m), int'(n), int'(k));
            q         = tq;
            exp_valid = 1;
          end
        end
      end else if (exp_valid) begin
        if (bus.cmd_ready) begin
          void'(q.pop_front());
          exp_valid = 0;
          awaiting  = 1;
        end
      end else if (awaiting && bus.tile_done) begin
        awaiting = 0;
        if (q.size() == 0) begin
          nd        = 1;
          finishing = 1;
        end else begin
          exp_valid = 1;
        end
      end
      exp_done = nd;
      exp_err  = ne;
    end
  end

  task automatic step(int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic kick(int mm, int nn, int kk);
    start = 1'b1;
    m     = DIM_W'(mm);
    n     = DIM_W'(nn);
    k     = DIM_W'(kk);
    step(1);
    start = 1'b0;
  endtask

  task automatic finish_wait(int maxc, int d0);
    for (int i = 0; i < maxc && dones == d0; i++) step(1);
    chk("op_done_count", dones - d0, 1);
    step(1);
  endtask

  initial begin
    int d0;
    int rb0;
    int cb0;
    int r0;
    int c0;
    bus.cmd_ready = 1'b1;

    build(5, 6, 3);
    chk("model_len", tq.size(), 4);
    chk("model_t1_cb", tq[1].cb, 4);
    chk("model_t1_cols", tq[1].cols, 2);
    chk("model_t2_rb", tq[2].rb, 4);
    chk("model_t2_rows", tq[2].rows, 1);
    chk("model_t3_cols", tq[3].cols, 2);
    build(15, 9, 1);
    chk("model_big_len", tq.size(), 12);
    chk("model_big_rows", tq[11].rows, 3);

    #1 rst = 1'b0;
    step(3);
    chk("reset_valid", int'(bus.cmd_valid), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_cnt", int'(cycle_cnt), 0);
    rst = 1'b1;
    step(2);

    // single full tile
    arr_delay = 4;
    d0 = dones;
    kick(4, 4, 4);
    chk("t1_valid", int'(bus.cmd_valid), 1);
    chk("t1_rows", int'(bus.cmd_rows), 4);
    chk("t1_k", int'(bus.cmd_k), 4);
    finish_wait(50, d0);
    chk("t1_cycle_cnt", int'(cycle_cnt), 6);

    // ragged 2x2 tiling
    arr_delay = 2;
    d0 = dones;
    kick(5, 6, 3);
    finish_wait(100, d0);
    step(3);
    chk("t2_one_done", dones - d0, 1);

    // back-pressure stall
    arr_delay = 3;
    bus.cmd_ready = 1'b0;
    d0 = dones;
    kick(4, 8, 2);
    rb0 = int'(bus.cmd_row_base);
    cb0 = int'(bus.cmd_col_base);
    r0  = int'(bus.cmd_rows);
    c0  = int'(bus.cmd_cols);
    chk("stall_first_cols", c0, 4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(bus.cmd_valid), 1);
      chk("stall_rb", int'(bus.cmd_row_base), rb0);
      chk("stall_cb", int'(bus.cmd_col_base), cb0);
      chk("stall_rows", int'(bus.cmd_rows), r0);
      step(1);
    end
    bus.cmd_ready = 1'b1;
    finish_wait(100, d0);

    // zero dimension
    d0 = dones;
    kick(3, 0, 2);
    chk("zero_done", int'(done), 1);
    chk("zero_err", int'(err), 1);
    chk("zero_valid", int'(bus.cmd_valid), 0);
    finish_wait(10, d0);
    chk("zero_cnt", int'(cycle_cnt), 1);

    // ignored start, dim change and stray tile_done
    arr_delay = 4;
    bus.cmd_ready = 1'b0;
    d0 = dones;
    kick(8, 4, 5);
    stray = 1'b1;
    step(1);
    stray = 1'b0;
    bus.cmd_ready = 1'b1;
    step(1);
    start = 1'b1;
    m = 4'd1;
    n = 4'd1;
    k = 4'd1;
    step(1);
    start = 1'b0;
    finish_wait(100, d0);

    // async reset while waiting on a tile
    kick(4, 4, 4);
    step(1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", int'(bus.cmd_valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_cnt", int'(cycle_cnt), 0);
    chk("async_rows", int'(bus.cmd_rows), 0);
    step(8);
    rst = 1'b1;
    step(1);
    arr_delay = 1;
    d0 = dones;
    kick(1, 1, 1);
    chk("post_rst_valid", int'(bus.cmd_valid), 1);
    chk("post_rst_rows", int'(bus.cmd_rows), 1);
    chk("post_rst_cols", int'(bus.cmd_cols), 1);
    chk("post_rst_k", int'(bus.cmd_k), 1);
    finish_wait(20, d0);
    chk("post_rst_cnt", int'(cycle_cnt), 3);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
